text_stream_sender: RTL and testbench
=====================================

// Module: text_stream_sender
// PURPOSE
// - Transmit side of the ASCII text-stream interface: takes 16-char message chunks from UI/control logic and emits them
//   one char per clk on ascii_data, framed by ascii_data_ready held high for the whole message.
// - Chained chunks (msg_last=0) form frames up to 2048 chars; a guaranteed idle gap separates frames so the scroller restarts at address 0.
// PARAMETERS
// - GAP_CYCLES  2     idle cycles with ascii_data_ready low between frames; minimum legal value 1
// - MAX_FRAME   2048  max chars per frame; later chars are truncated
// PORTS
// - clk              in   1    system clock
// - reset            in   1    asynchronous, active-high reset
// - msg_data         in   128  chunk; char 0 in [127:120], char 15 in [7:0]
// - msg_len          in   5    chars in chunk: 0..16, values >16 clamp to 16
// - msg_last         in   1    chunk ends the frame
// - msg_valid        in   1    chunk offered
// - msg_ready        out  1    buffer has a free slot; transfer when msg_valid & msg_ready
// - ascii_data       out  8    current char; 8'h20 when not sending
// - ascii_data_ready out  1    frame active; high for exactly the frame's char count, no holes
// - busy             out  1    state != IDLE or any chunk buffered
// - err_underrun     out  1    sticky; chunk with last=0 ended with no next chunk buffered
// - err_trunc        out  1    sticky; frame exceeded MAX_FRAME
// BEHAVIOUR
// - Reset: state IDLE, buffer empty, msg_ready=1, ascii_data=8'h20, ascii_data_ready=0, busy=0, err_*=0. Async assert
//   mid-frame aborts the frame at once; no char is ever emitted after reset asserts.
// - All outputs are registered. 2-entry chunk FIFO (ping-pong); msg_ready = !full; a push while full cannot occur.
// - FSM IDLE -> SEND -> GAP -> IDLE.
//   IDLE: head chunk present with len>0 -> SEND; first char on ascii_data/ready the cycle after head became valid.
//     A transfer at edge T shows char 0 at edge T+1.
//     A len=0 chunk is popped in 1 cycle with no output. If last=0, the frame stays unopened.
//   SEND: 1 char/cycle, char index idx 0..len-1, frame count fcnt (11 bit) +1 per char.
//     At idx=len-1: pop chunk. If last=1 -> GAP. If last=0 and next chunk present -> its char 0 on the next cycle, no bubble.
//     If last=0 and FIFO empty -> set err_underrun and go to GAP, so the frame closes short.
//     Next chunk with len=0 and last=0: popped and skipped in the same cycle; its last=1 closes the frame.
//   fcnt reaches MAX_FRAME: set err_trunc and go to GAP. Remaining chunks are popped silently up to and including last=1.
//   GAP: ascii_data_ready=0 for exactly GAP_CYCLES, then IDLE. Chunks can be accepted during GAP.
// - Push and pop in the same cycle are allowed; occupancy stays the same. Error flags clear only on reset.
// CONFIGURATION
// - `TEXT_SENDER_TRIM_EN defined: msg_len ignored.
//   Effective length = 1 + index of the last non-8'h20 char; an all-space chunk has length 0.
//   This drops trailing blanks of padded 16-char labels.
// - Not defined: the clamped msg_len is used verbatim and spaces are sent as data.
// STRUCTURE
// - Package text_ui_pkg: CHAR_SPACE=8'h20, DISP_CHARS=16, MAX_FRAME_DEFAULT=2048, state enum {IDLE,SEND,GAP}, chunk
//   struct {data[127:0],len[4:0],last}.
// - Sub-module text_chunk_fifo: 2-entry chunk FIFO with full/empty and head outputs.
// - Top holds the FSM, the idx/fcnt/gap counters, char select (msg_data >> 8*(15-idx)) and trim logic.
// TESTING
// - Single chunk "HELLO" len=5 last=1 -> ascii_data 48,45,4C,4C,4F with ready high exactly 5 cycles, then ready low >=2 cycles.
// - Two chunks of 16 + 4 chars, last=0 then 1, both buffered -> 20 consecutive ready cycles, no bubble, err_underrun=0.
// - Chunk len=16 last=0 with no follow-up -> 16 chars, ready falls, err_underrun=1.
//   A later frame is emitted normally and the flag stays set.
// - Stream 129 chunks of 16 chars, last only on the final chunk -> ready high exactly 2048 cycles, err_trunc=1.
//   Surplus chunks are consumed; msg_ready returns to 1.
// - Async reset asserted mid-frame at char 7 -> same cycle ascii_data_ready=0, ascii_data=8'h20, msg_ready=1, busy=0.
// - TRIM_EN: "OK" plus 14 spaces with msg_len=16 -> 2 chars emitted; all-space chunk with last=1 -> no ready pulse.

Source files
------------

// File: rtl/text_ui_pkg.sv
// text_ui_pkg: shared constants, FSM states and chunk record for the text stream sender
package text_ui_pkg;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam int DISP_CHARS = 16;
  localparam int MAX_FRAME_DEFAULT = 2048;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   len;
    logic         last;
  } chunk_t;
  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return len > 5'(DISP_CHARS) ? 5'(DISP_CHARS) : len;
  endfunction
endpackage

// File: rtl/text_chunk_fifo.sv
// text_chunk_fifo: two-entry ping-pong chunk buffer exposing the head chunk and a peek at the next one
// Ports: clk, reset (async, active-high); push/push_chunk write; pop removes one, pop2 removes two;
// head, next_len, next_last peek; cnt occupancy, full, empty.
module text_chunk_fifo
  import text_ui_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  chunk_t     push_chunk,
  input  logic       pop,
  input  logic       pop2,
  output chunk_t     head,
  output logic [4:0] next_len,
  output logic       next_last,
  output logic [1:0] cnt,
  output logic       full,
  output logic       empty
);
  chunk_t mem_q [2];
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q ^ push;
    // pop2 advances the 1-bit read pointer twice, which leaves it unchanged
    rd_d = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {pop2, pop};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= push_chunk;
  assign head = mem_q[rd_q];
  assign next_len = mem_q[~rd_q].len;
  assign next_last = mem_q[~rd_q].last;
  assign cnt = cnt_q;
  assign full = cnt_q[1];
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/text_stream_sender.sv
// text_stream_sender: emits buffered 16-char chunks one char per clk on ascii_data, framed by ascii_data_ready
// Ports: clk, reset (async, active-high); msg_data/msg_len/msg_last/msg_valid/msg_ready chunk input;
// ascii_data/ascii_data_ready registered char stream; busy; err_underrun/err_trunc sticky errors.
// Build option: define TEXT_SENDER_TRIM_EN to take chunk length from the last non-space char instead of msg_len.
module text_stream_sender
  import text_ui_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_FRAME  = MAX_FRAME_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] msg_data,
  input  logic [4:0]   msg_len,
  input  logic         msg_last,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic [7:0]   ascii_data,
  output logic         ascii_data_ready,
  output logic         busy,
  output logic         err_underrun,
  output logic         err_trunc
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  chunk_t head, in_chunk;
  logic [4:0] in_len, next_len;
  logic next_last, full, empty, push, pop, pop2, emit, last_ch;
  logic [1:0] cnt, cnt_nx;
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [10:0] fcnt_q, fcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic drain_q, drain_d, und_q, und_d, trunc_q, trunc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [7:0] data_q, data_d;
`ifdef TEXT_SENDER_TRIM_EN
  always_comb begin
    in_len = '0;
    for (int i = 0; i < DISP_CHARS; i++) if (msg_data[127-8*i -: 8] != CHAR_SPACE) in_len = 5'(i + 1);
  end
`else
  assign in_len = clamp_len(msg_len);
`endif
  assign push = msg_valid & ~full;
  assign in_chunk = {msg_data, in_len, msg_last};
  text_chunk_fifo u_fifo (
    .clk,
    .reset,
    .push,
    .push_chunk(in_chunk),
    .pop,
    .pop2,
    .head,
    .next_len,
    .next_last,
    .cnt,
    .full,
    .empty
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fcnt_d = fcnt_q;
    gap_d = gap_q;
    drain_d = drain_q;
    und_d = und_q;
    trunc_d = trunc_q;
    data_d = CHAR_SPACE;
    rdy_d = 1'b0;
    pop = 1'b0;
    pop2 = 1'b0;
    emit = state_q == SEND || (state_q == IDLE && !empty && !drain_q && head.len != 5'd0);
    last_ch = {1'b0, idx_q} == head.len - 5'd1;
    if (state_q == GAP) begin
      state_d = gap_q == '0 ? IDLE : GAP;
      gap_d = gap_q - GW'(1);
    end
    // empty chunks in IDLE and leftovers of a truncated frame are discarded one per cycle
    if (!emit && !empty && (drain_q || state_q == IDLE)) begin
      pop = 1'b1;
      drain_d = drain_q && !head.last;
    end
    if (emit) begin
      data_d = 8'(head.data >> {~idx_q, 3'b000});
      rdy_d = 1'b1;
      fcnt_d = fcnt_q + 11'd1;
      idx_d = idx_q + 4'd1;
      state_d = SEND;
      if (fcnt_q == 11'(MAX_FRAME - 1) && !(last_ch && head.last)) begin
        pop = 1'b1;
        trunc_d = 1'b1;
        drain_d = !head.last;
        state_d = GAP;
      end else if (last_ch) begin
        idx_d = '0;
        // an empty follow-up chunk is consumed together with the finishing one so no hole appears
        pop2 = !head.last && cnt == 2'd2 && next_len == 5'd0;
        pop = !pop2;
        und_d = und_q || (!head.last && (cnt != 2'd2 || (pop2 && !next_last)));
        state_d = (head.last || cnt != 2'd2 || pop2) ? GAP : SEND;
      end
    end
    if (state_d == GAP && state_q != GAP) begin
      gap_d = GW'(GAP_CYCLES - 1);
      fcnt_d = '0;
      idx_d = '0;
    end
    cnt_nx = cnt + {1'b0, push} - {pop2, pop};
    busy_d = state_d != IDLE || cnt_nx != 2'd0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      fcnt_q <= '0;
      gap_q <= '0;
      drain_q <= 1'b0;
      und_q <= 1'b0;
      trunc_q <= 1'b0;
      data_q <= CHAR_SPACE;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fcnt_q <= fcnt_d;
      gap_q <= gap_d;
      drain_q <= drain_d;
      und_q <= und_d;
      trunc_q <= trunc_d;
      data_q <= data_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
    end
  assign msg_ready = ~full;
  assign ascii_data = data_q;
  assign ascii_data_ready = rdy_q;
  assign busy = busy_q;
  assign err_underrun = und_q;
  assign err_trunc = trunc_q;
endmodule

// File: tb/tb_text_stream_sender.sv
// tb_text_stream_sender: directed stimulus checked against a frame-level model of the sender
module tb_text_stream_sender;
  localparam int GAP = 2;
  localparam int MAXF = 2048;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [127:0] msg_data = '0;
  logic [4:0] msg_len = '0;
  logic msg_last = 1'b0;
  logic msg_valid = 1'b0;
  logic msg_ready, ascii_data_ready, busy, err_underrun, err_trunc;
  logic [7:0] ascii_data;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int exp_len[$];
  int got_len[$];
  int cur_len = 0;
  logic exp_und = 1'b0;
  logic exp_trunc = 1'b0;
  int run = 0;
  int low = 1000;
  logic [7:0] hello_b [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  localparam logic [127:0] ALPHA = "ABCDEFGHIJKLMNOP";
  localparam logic [127:0] SPACES = {16{8'h20}};
  always #5 clk = ~clk;
  text_stream_sender #(.GAP_CYCLES(GAP), .MAX_FRAME(MAXF)) dut (
    .clk(clk),
    .reset(reset),
    .msg_data(msg_data),
    .msg_len(msg_len),
    .msg_last(msg_last),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .ascii_data(ascii_data),
    .ascii_data_ready(ascii_data_ready),
    .busy(busy),
    .err_underrun(err_underrun),
    .err_trunc(err_trunc)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void model_close();
    if (cur_len > 0) exp_len.push_back(cur_len);
    cur_len = 0;
  endfunction
  function automatic void model_add(input logic [127:0] d, input logic [4:0] l, input logic la);
    int n = (l > 5'd16) ? 16 : int'(l);
`ifdef TEXT_SENDER_TRIM_EN
    n = 0;
    for (int i = 0; i < 16; i++) if (d[127-8*i -: 8] != 8'h20) n = i + 1;
`endif
    for (int i = 0; i < n; i++) begin
      if (cur_len < MAXF) begin
        exp_q.push_back(d[127-8*i -: 8]);
        cur_len++;
      end else exp_trunc = 1'b1;
    end
    if (la) model_close();
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
      low = 1000;
    end else if (ascii_data_ready) begin
      if (run == 0) chk("gap_len_ok", 32'(low >= GAP), 1);
      chk("char_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("char", ascii_data, exp_q.pop_front());
      run++;
      low = 0;
    end else begin
      chk("idle_space", ascii_data, 8'h20);
      if (run != 0) got_len.push_back(run);
      run = 0;
      low++;
    end
  end
  task automatic send(input logic [127:0] d, input logic [4:0] l, input logic la);
    int n = 0;
    msg_data = d;
    msg_len = l;
    msg_last = la;
    msg_valid = 1'b1;
    while (!msg_ready && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("msg_ready_wait", msg_ready, 1);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    model_add(d, l, la);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((busy || ascii_data_ready) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
    repeat (GAP + 2) @(posedge clk);
    #1;
    chk("err_underrun", err_underrun, exp_und);
    chk("err_trunc", err_trunc, exp_trunc);
    chk("frame_count", got_len.size(), exp_len.size());
    while (got_len.size() != 0 && exp_len.size() != 0) chk("frame_len", got_len.pop_front(), exp_len.pop_front());
    got_len.delete();
    exp_len.delete();
    chk("chars_left", exp_q.size(), 0);
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_msg_ready", msg_ready, 1);
    chk("rst_ascii_data", ascii_data, 8'h20);
    chk("rst_ready", ascii_data_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_underrun", err_underrun, 0);
    chk("rst_err_trunc", err_trunc, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // single chunk: char 0 one edge after the transfer, 5 chars, then at least GAP low cycles
    send({"HELLO", {11{8'h20}}}, 5'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hello_char", ascii_data, hello_b[i]);
      chk("hello_ready", ascii_data_ready, 1);
    end
    for (int i = 0; i < GAP; i++) begin
      @(posedge clk);
      #1;
      chk("hello_gap_low", ascii_data_ready, 0);
    end
    wait_idle();
    // 16 (msg_len 31 clamps) + 4 chars chained with no bubble
    send(ALPHA, 5'd31, 1'b0);
    send({"QRST", {12{8'h20}}}, 5'd4, 1'b1);
    chk("model_len20", exp_len[0], 20);
    wait_idle();
    // empty chunks: alone, closing a frame, and leading an unopened frame
    send(SPACES, 5'd0, 1'b1);
    send({"AB", {14{8'h20}}}, 5'd2, 1'b0);
    send(SPACES, 5'd0, 1'b1);
    wait_idle();
    send(SPACES, 5'd0, 1'b0);
    send({"CD", {14{8'h20}}}, 5'd2, 1'b1);
    wait_idle();
    // two back-to-back one-chunk frames must be separated by the idle gap
    send({"AB", {14{8'h20}}}, 5'd2, 1'b1);
    send({"CD", {14{8'h20}}}, 5'd2, 1'b1);
    wait_idle();
    // interior spaces are always data; trailing padding is dropped only with trimming
    send({"A B", {13{8'h20}}}, 5'd3, 1'b1);
    send({"OK", {14{8'h20}}}, 5'd16, 1'b1);
`ifdef TEXT_SENDER_TRIM_EN
    chk("model_len_ok", exp_len[1], 2);
`else
    chk("model_len_ok", exp_len[1], 16);
`endif
    wait_idle();
    // underrun: chained chunk with no follow-up closes the frame short
    send(ALPHA, 5'd16, 1'b0);
    model_close();
    exp_und = 1'b1;
    wait_idle();
    chk("underrun_set", err_underrun, 1);
    send({"HI", {14{8'h20}}}, 5'd2, 1'b1);
    wait_idle();
    chk("underrun_sticky", err_underrun, 1);
    // 129 chained chunks: frame truncated at MAXF, surplus consumed
    for (int k = 0; k < 129; k++) send(ALPHA, 5'd16, k == 128);
    chk("model_len2048", exp_len[0], 2048);
    wait_idle();
    chk("trunc_set", err_trunc, 1);
    chk("trunc_msg_ready", msg_ready, 1);
    // async reset while char 7 is on the bus
    send(ALPHA, 5'd16, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_char7", ascii_data, 8'h48);
    chk("pre_reset_ready", ascii_data_ready, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", ascii_data_ready, 0);
    chk("mid_rst_ascii", ascii_data, 8'h20);
    chk("mid_rst_msg_ready", msg_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_underrun", err_underrun, 0);
    chk("mid_rst_err_trunc", err_trunc, 0);
    exp_q.delete();
    exp_len.delete();
    got_len.delete();
    cur_len = 0;
    exp_und = 1'b0;
    exp_trunc = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send({"HELLO", {11{8'h20}}}, 5'd5, 1'b1);
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
